// File: rtl/truth_table_sweep.sv
// Truth-table sweep engine: on start, latches two M-bit truth tables and walks
// every minterm once, accumulating ones counts, agreement count and the lowest
// disagreeing minterm. Results are held in IDLE until the next accepted start.
module truth_table_sweep #(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [(1<<N)-1:0]  mask_a,
  input  logic [(1<<N)-1:0]  mask_b,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       m,
  output logic               sa,
  output logic               sb,
  output logic [N:0]         ones_a,
  output logic [N:0]         ones_b,
  output logic [N:0]         match_count,
  output logic               mismatch,
  output logic [N-1:0]       first_mismatch
);

  localparam int M = 1 << N;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   ma_q, ma_d;
  logic [M-1:0]   mb_q, mb_d;
  logic [N-1:0]   m_q, m_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [N:0]     ones_a_q, ones_a_d;
  logic [N:0]     ones_b_q, ones_b_d;
  logic [N:0]     match_q, match_d;
  logic           mis_q, mis_d;
  logic [N-1:0]   fm_q, fm_d;
  logic           a_bit, b_bit;

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    m_d      = m_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ones_a_d = ones_a_q;
    ones_b_d = ones_b_q;
    match_d  = match_q;
    mis_d    = mis_q;
    fm_d     = fm_q;
    a_bit    = ma_q[m_q];
    b_bit    = mb_q[m_q];
    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d     = mask_a;
          mb_d     = mask_b;
          m_d      = '0;
          ones_a_d = '0;
          ones_b_d = '0;
          match_d  = '0;
          mis_d    = 1'b0;
          fm_d     = '0;
          state_d  = SWEEP;
        end
      end
      SWEEP: begin
        sa_d     = a_bit;
        sb_d     = b_bit;
        ones_a_d = ones_a_q + (N+1)'(a_bit);
        ones_b_d = ones_b_q + (N+1)'(b_bit);
        match_d  = match_q + (N+1)'(a_bit == b_bit);
        // Minterms are visited in ascending order, so the first disagreement
        // seen is the lowest index; later ones leave it untouched.
        if ((a_bit != b_bit) && !mis_q) begin
          mis_d = 1'b1;
          fm_d  = m_q;
        end
        if (m_q == N'(M - 1)) begin
          state_d = DONE;
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ma_q     <= '0;
      mb_q     <= '0;
      m_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ones_a_q <= '0;
      ones_b_q <= '0;
      match_q  <= '0;
      mis_q    <= 1'b0;
      fm_q     <= '0;
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      m_q      <= m_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ones_a_q <= ones_a_d;
      ones_b_q <= ones_b_d;
      match_q  <= match_d;
      mis_q    <= mis_d;
      fm_q     <= fm_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign m              = m_q;
  assign sa             = sa_q;
  assign sb             = sb_q;
  assign ones_a         = ones_a_q;
  assign ones_b         = ones_b_q;
  assign match_count    = match_q;
  assign mismatch       = mis_q;
  assign first_mismatch = fm_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: an N=2 instance for most scenarios and
// an N=3 instance for the all-ones no-wrap case.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=2 instance
  logic       reset2 = 1'b1, start2 = 1'b0;
  logic [3:0] mask_a2 = '0, mask_b2 = '0;
  logic       busy2, done2, sa2, sb2, mis2;
  logic [1:0] m2, fm2;
  logic [2:0] oa2, ob2, mc2;

  // N=3 instance
  logic       reset3 = 1'b1, start3 = 1'b0;
  logic [7:0] mask_a3 = '0, mask_b3 = '0;
  logic       busy3, done3, sa3, sb3, mis3;
  logic [2:0] m3, fm3;
  logic [3:0] oa3, ob3, mc3;

  truth_table_sweep #(.N(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .mask_a(mask_a2), .mask_b(mask_b2),
    .busy(busy2), .done(done2), .m(m2), .sa(sa2), .sb(sb2),
    .ones_a(oa2), .ones_b(ob2), .match_count(mc2),
    .mismatch(mis2), .first_mismatch(fm2)
  );

  truth_table_sweep #(.N(3)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .mask_a(mask_a3), .mask_b(mask_b3),
    .busy(busy3), .done(done3), .m(m3), .sa(sa3), .sb(sb3),
    .ones_a(oa3), .ones_b(ob3), .match_count(mc3),
    .mismatch(mis3), .first_mismatch(fm3)
  );

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep on the N=2 instance and wait (bounded) for done.
  task automatic sweep2(input logic [3:0] a, input logic [3:0] b);
    int n;
    mask_a2 = a;
    mask_b2 = b;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    n = 0;
    while (!done2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done2 !== 1'b1) begin
      errors++;
      $display("FAIL sweep2_timeout: done=%b required 1", done2);
    end
    tick();
  endtask

  task automatic test_reset();
    reset2 = 1'b1;
    reset3 = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy2, done2, m2, sa2, sb2, oa2, ob2, mc2, mis2, fm2} !== '0) begin
      errors++;
      $display("FAIL reset2: outputs=%b required all 0",
               {busy2, done2, m2, sa2, sb2, oa2, ob2, mc2, mis2, fm2});
    end
    checks++;
    if ({busy3, done3, m3, sa3, sb3, oa3, ob3, mc3, mis3, fm3} !== '0) begin
      errors++;
      $display("FAIL reset3: outputs=%b required all 0",
               {busy3, done3, m3, sa3, sb3, oa3, ob3, mc3, mis3, fm3});
    end
    reset2 = 1'b0;
    reset3 = 1'b0;
    tick();
  endtask

  // a'.b vs NAND, step by step
  task automatic test_basic();
    logic [3:0] exp_sa, exp_sb;
    exp_sa = 4'b0010;
    exp_sb = 4'b0111;
    mask_a2 = 4'b0010;
    mask_b2 = 4'b0111;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: busy=%b done=%b required busy=1 done=0", busy2, done2);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m2 !== 2'(i)) begin
        errors++;
        $display("FAIL basic_m%0d: m=%0d required %0d", i, m2, i);
      end
      tick();
      checks++;
      if (sa2 !== exp_sa[i] || sb2 !== exp_sb[i]) begin
        errors++;
        $display("FAIL basic_sasb%0d: sa=%b sb=%b required sa=%b sb=%b",
                 i, sa2, sb2, exp_sa[i], exp_sb[i]);
      end
      checks++;
      if (done2 !== (i == 3)) begin
        errors++;
        $display("FAIL basic_done%0d: done=%b required %b", i, done2, (i == 3));
      end
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b required 0 0", done2, busy2);
    end
    checks++;
    if (oa2 !== 3'd1 || ob2 !== 3'd3 || mc2 !== 3'd2 || mis2 !== 1'b1 || fm2 !== 2'd0) begin
      errors++;
      $display("FAIL basic_result: ones_a=%0d ones_b=%0d match=%0d mis=%b fm=%0d required 1 3 2 1 0",
               oa2, ob2, mc2, mis2, fm2);
    end
  endtask

  task automatic test_hold_idle();
    mask_a2 = 4'b1111;
    mask_b2 = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (oa2 !== 3'd1 || ob2 !== 3'd3 || mc2 !== 3'd2 || mis2 !== 1'b1 || fm2 !== 2'd0 ||
        m2 !== 2'd3 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: ones_a=%0d ones_b=%0d match=%0d mis=%b fm=%0d m=%0d busy=%b required 1 3 2 1 0 3 0",
               oa2, ob2, mc2, mis2, fm2, m2, busy2);
    end
  endtask

  task automatic test_equal();
    sweep2(4'b0010, 4'b0010);
    checks++;
    if (oa2 !== 3'd1 || ob2 !== 3'd1 || mc2 !== 3'd4 || mis2 !== 1'b0) begin
      errors++;
      $display("FAIL equal: ones_a=%0d ones_b=%0d match=%0d mis=%b required 1 1 4 0",
               oa2, ob2, mc2, mis2);
    end
  endtask

  // First mismatch at the last minterm, then first of two mismatches kept
  task automatic test_first_mismatch();
    sweep2(4'b1000, 4'b0000);
    checks++;
    if (mis2 !== 1'b1 || fm2 !== 2'd3 || mc2 !== 3'd3 || oa2 !== 3'd1) begin
      errors++;
      $display("FAIL fm_last: mis=%b fm=%0d match=%0d ones_a=%0d required 1 3 3 1",
               mis2, fm2, mc2, oa2);
    end
    sweep2(4'b1100, 4'b0000);
    checks++;
    if (mis2 !== 1'b1 || fm2 !== 2'd2 || mc2 !== 3'd2 || oa2 !== 3'd2) begin
      errors++;
      $display("FAIL fm_keep: mis=%b fm=%0d match=%0d ones_a=%0d required 1 2 2 2",
               mis2, fm2, mc2, oa2);
    end
  endtask

  task automatic test_no_wrap();
    int n;
    mask_a3 = 8'hFF;
    mask_b3 = 8'h00;
    start3  = 1'b1;
    tick();
    start3  = 1'b0;
    n = 0;
    while (!done3 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (done3 !== 1'b1 || n !== 8) begin
      errors++;
      $display("FAIL n3_latency: done=%b cycles=%0d required 1 8", done3, n);
    end
    checks++;
    if (oa3 !== 4'd8 || ob3 !== 4'd0 || mc3 !== 4'd0 || mis3 !== 1'b1 || fm3 !== 3'd0) begin
      errors++;
      $display("FAIL n3_nowrap: ones_a=%0d ones_b=%0d match=%0d mis=%b fm=%0d required 8 0 0 1 0",
               oa3, ob3, mc3, mis3, fm3);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    mask_a2 = 4'b0010;
    mask_b2 = 4'b0111;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    tick();
    tick();
    checks++;
    if (m2 !== 2'd2 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL abort_pos: m=%0d busy=%b required 2 1", m2, busy2);
    end
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    checks++;
    if ({busy2, done2, m2, sa2, sb2, oa2, ob2, mc2, mis2, fm2} !== '0) begin
      errors++;
      $display("FAIL abort_reset: outputs=%b required all 0",
               {busy2, done2, m2, sa2, sb2, oa2, ob2, mc2, mis2, fm2});
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done2) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_nodone: done pulses=%0d required 0", dones);
    end
    sweep2(4'b0110, 4'b0011);
    checks++;
    if (oa2 !== 3'd2 || ob2 !== 3'd2 || mc2 !== 3'd2 || mis2 !== 1'b1 || fm2 !== 2'd0) begin
      errors++;
      $display("FAIL abort_clean: ones_a=%0d ones_b=%0d match=%0d mis=%b fm=%0d required 2 2 2 1 0",
               oa2, ob2, mc2, mis2, fm2);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    mask_a2 = 4'b0010;
    mask_b2 = 4'b0111;
    start2  = 1'b1;
    tick();
    start2  = 1'b0;
    dones   = 0;
    tick();
    mask_a2 = 4'b1111;
    mask_b2 = 4'b0000;
    start2  = 1'b1;
    tick();
    checks++;
    if (m2 !== 2'd2) begin
      errors++;
      $display("FAIL ignore_m: m=%0d required 2", m2);
    end
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done2) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_dones: done pulses=%0d required 1", dones);
    end
    checks++;
    if (oa2 !== 3'd1 || ob2 !== 3'd3 || mc2 !== 3'd2 || mis2 !== 1'b1 || fm2 !== 2'd0) begin
      errors++;
      $display("FAIL ignore_result: ones_a=%0d ones_b=%0d match=%0d mis=%b fm=%0d required 1 3 2 1 0",
               oa2, ob2, mc2, mis2, fm2);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, dones;
    first   = -1;
    second  = -1;
    dones   = 0;
    mask_a2 = 4'b0010;
    mask_b2 = 4'b0111;
    start2  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done2) begin
        dones++;
        if (first < 0) first = i; else second = i;
        checks++;
        if (oa2 !== 3'd1 || ob2 !== 3'd3 || mc2 !== 3'd2 || fm2 !== 2'd0) begin
          errors++;
          $display("FAIL b2b_result%0d: ones_a=%0d ones_b=%0d match=%0d fm=%0d required 1 3 2 0",
                   dones, oa2, ob2, mc2, fm2);
        end
      end
    end
    start2 = 1'b0;
    checks++;
    if (dones !== 2 || first !== 5 || second !== 11) begin
      errors++;
      $display("FAIL b2b_timing: pulses=%0d at %0d,%0d required 2 at 5,11", dones, first, second);
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_idle();
    test_equal();
    test_first_mismatch();
    test_no_wrap();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
